// File: rtl/vga_pkg.sv
`default_nettype none
`timescale 1ns / 1ps
// ============================================================================
// Module      : vga_pkg
// Description : 1024x768@60 timing constants shared by the VGA draw pipeline.
// Revision    : 1.0 - initial release
// ============================================================================
package vga_pkg;

    localparam int HOR_PIXELS = 1024;
    localparam int VER_PIXELS = 768;
    localparam int HOR_TOTAL  = 1344;
    localparam int VER_TOTAL  = 806;
    localparam int CNT_W      = 11;

endpackage
`default_nettype wire

// File: rtl/vga_if.sv
`default_nettype none
`timescale 1ns / 1ps
// ============================================================================
// Module      : vga_if
// Description : VGA stream bundle (counters, syncs, blanks, colour).
// Revision    : 1.0 - initial release
// ============================================================================
interface vga_if;
    import vga_pkg::*;

    logic [CNT_W-1:0] hcount;
    logic [CNT_W-1:0] vcount;
    logic             hsync;
    logic             vsync;
    logic             hblnk;
    logic             vblnk;
    logic [11:0]      rgb;

    modport master (output hcount, vcount, hsync, vsync, hblnk, vblnk, rgb);
    modport slave  (input  hcount, vcount, hsync, vsync, hblnk, vblnk, rgb);
endinterface
`default_nettype wire

// File: rtl/sig_delay.sv
`default_nettype none
`timescale 1ns / 1ps
// ============================================================================
// Module      : sig_delay
// Description : WIDTH-bit shift register, DEPTH stages, synchronous reset to 0.
// Revision    : 1.0 - initial release
// ============================================================================
module sig_delay #(
    parameter int WIDTH = 1,
    parameter int DEPTH = 1
) (
    input  wire logic             clk,
    input  wire logic             rst,
    input  wire logic [WIDTH-1:0] din,
    output logic      [WIDTH-1:0] dout
);

    generate
        if (DEPTH == 0) begin : g_bypass
            assign dout = din;
        end else begin : g_shift
            logic [WIDTH-1:0] stage_q [DEPTH];
            logic [WIDTH-1:0] stage_d [DEPTH];

            always_comb begin
                stage_d[0] = din;
                for (int i = 1; i < DEPTH; i++) begin
                    stage_d[i] = stage_q[i-1];
                end
            end

            always_ff @(posedge clk) begin
                if (rst) begin
                    for (int i = 0; i < DEPTH; i++) begin
                        stage_q[i] <= '0;
                    end
                end else begin
                    stage_q <= stage_d;
                end
            end

            assign dout = stage_q[DEPTH-1];
        end
    endgenerate

endmodule
`default_nettype wire

// File: rtl/draw_image.sv
`default_nettype none
`timescale 1ns / 1ps
// ============================================================================
// Module      : draw_image
// Description : Overlays a ROM image at a frame-latched position with 2^n
//               upscaling. Optional DRAW_IMAGE_TRANSPARENCY_EN keys out
//               KEY_COLOR pixels.
// Revision    : 1.0 - initial release
// ============================================================================
module draw_image
    import vga_pkg::*;
#(
    parameter int          IMG_W       = 128,
    parameter int          IMG_H       = 96,
    parameter int          ADDR_W      = 14,
    parameter int          SCALE_LOG2  = 0,
    parameter int          ROM_LATENCY = 1,
    parameter logic [11:0] KEY_COLOR   = 12'hF0F
) (
    input  wire logic              clk,
    input  wire logic              rst,
    input  wire logic              en,
    input  wire logic [10:0]       xpos,
    input  wire logic [10:0]       ypos,
    output logic      [ADDR_W-1:0] pixel_addr,
    input  wire logic [11:0]       rgb_pixel,
    vga_if.slave                   in,
    vga_if.master                  out
);

    localparam int          LAT   = ROM_LATENCY + 1;
    localparam logic [11:0] WIN_W = 12'(IMG_W << SCALE_LOG2);
    localparam logic [11:0] WIN_H = 12'(IMG_H << SCALE_LOG2);
    localparam int          BUS_W = 2 * CNT_W + 4 + 12 + 1;

    logic              vsync_d, vsync_q;
    logic              en_l_d, en_l_q;
    logic [10:0]       xpos_l_d, xpos_l_q;
    logic [10:0]       ypos_l_d, ypos_l_q;
    logic [ADDR_W-1:0] pixel_addr_d, pixel_addr_q;
    logic [BUS_W-1:0]  bus_d, bus_q;
    logic [BUS_W-1:0]  w_bus_dly;

    logic              w_frame_start;
    logic              w_inside;
    logic [11:0]       w_x_end, w_y_end;
    logic [CNT_W-1:0]  w_dx, w_dy;

    // Latched values are bypassed on the frame-start cycle so a window that
    // begins exactly there already uses the new position.
    always_comb begin
        w_frame_start = in.vsync & ~vsync_q;
        vsync_d       = in.vsync;
        en_l_d        = en_l_q;
        xpos_l_d      = xpos_l_q;
        ypos_l_d      = ypos_l_q;
        if (w_frame_start) begin
            en_l_d   = en;
            xpos_l_d = xpos;
            ypos_l_d = ypos;
        end

        w_x_end  = {1'b0, xpos_l_d} + WIN_W;
        w_y_end  = {1'b0, ypos_l_d} + WIN_H;
        w_inside = en_l_d
                && (in.hcount >= xpos_l_d) && ({1'b0, in.hcount} < w_x_end)
                && (in.vcount >= ypos_l_d) && ({1'b0, in.vcount} < w_y_end);

        w_dx = in.hcount - xpos_l_d;
        w_dy = in.vcount - ypos_l_d;

        pixel_addr_d = '0;
        if (w_inside) begin
            pixel_addr_d = ADDR_W'(w_dy >> SCALE_LOG2) * ADDR_W'(IMG_W)
                         + ADDR_W'(w_dx >> SCALE_LOG2);
        end

        bus_d = {in.hcount, in.vcount, in.hsync, in.vsync,
                 in.hblnk, in.vblnk, in.rgb, w_inside};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            vsync_q      <= 1'b0;
            en_l_q       <= 1'b0;
            xpos_l_q     <= '0;
            ypos_l_q     <= '0;
            pixel_addr_q <= '0;
            bus_q        <= '0;
        end else begin
            vsync_q      <= vsync_d;
            en_l_q       <= en_l_d;
            xpos_l_q     <= xpos_l_d;
            ypos_l_q     <= ypos_l_d;
            pixel_addr_q <= pixel_addr_d;
            bus_q        <= bus_d;
        end
    end

    assign pixel_addr = pixel_addr_q;

    // Remaining ROM_LATENCY stages align the stream with rgb_pixel.
    sig_delay #(
        .WIDTH (BUS_W),
        .DEPTH (LAT - 1)
    ) u_sig_delay (
        .clk  (clk),
        .rst  (rst),
        .din  (bus_q),
        .dout (w_bus_dly)
    );

    logic [CNT_W-1:0] w_d_hcount, w_d_vcount;
    logic             w_d_hsync, w_d_vsync, w_d_hblnk, w_d_vblnk, w_d_inside;
    logic [11:0]      w_d_rgb;
    logic [11:0]      w_rgb_out;
    logic             w_show_rom;

    assign {w_d_hcount, w_d_vcount, w_d_hsync, w_d_vsync,
            w_d_hblnk, w_d_vblnk, w_d_rgb, w_d_inside} = w_bus_dly;

    always_comb begin
`ifdef DRAW_IMAGE_TRANSPARENCY_EN
        w_show_rom = w_d_inside && (rgb_pixel != KEY_COLOR);
`else
        w_show_rom = w_d_inside;
`endif
        w_rgb_out = w_d_rgb;
        if (w_d_hblnk || w_d_vblnk) begin
            w_rgb_out = 12'h000;
        end else if (w_show_rom) begin
            w_rgb_out = rgb_pixel;
        end
    end

    assign out.hcount = w_d_hcount;
    assign out.vcount = w_d_vcount;
    assign out.hsync  = w_d_hsync;
    assign out.vsync  = w_d_vsync;
    assign out.hblnk  = w_d_hblnk;
    assign out.vblnk  = w_d_vblnk;
    assign out.rgb    = w_rgb_out;

endmodule
`default_nettype wire
